unibus_memslave: RTL and testbench

- Unibus slave memory responder: the target end of the MSYN/SSYN data-transfer handshake that the console DMA master initiates.
- Answers DATI/DATIP/DATO/DATOB cycles for an ARM-programmed byte-address window from an internal word RAM.
- Provides the ARM side with configuration, a transaction counter and a backdoor RAM port, using the same 8-register arm read/write interface as the other Zynq bus devices.

---
 rtl/unibus_pkg.sv | 30 +++
 rtl/unibus_memslave_ram.sv | 23 ++
 rtl/unibus_memslave.sv | 207 ++++++++++++++++++++
 tb/tb_unibus_memslave.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/unibus_pkg.sv
// Shared definitions for the Unibus memory slave: bus control codes,
// I/O page boundary, ARM register constants and the responder state type.
package unibus_pkg;

  localparam logic [1:0] C_DATI  = 2'b00;
  localparam logic [1:0] C_DATIP = 2'b01;
  localparam logic [1:0] C_DATO  = 2'b10;
  localparam logic [1:0] C_DATOB = 2'b11;

  localparam logic [17:0] IOPAGE_BASE = 18'o760000;

  localparam logic [31:0] ID_WORD  = 32'h554D2001;
  localparam logic [31:0] BAD_WORD = 32'hDEADBEEF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_QUAL,
    ST_RDWAIT,
    ST_SSYN,
    ST_NOHIT,
    ST_BDOOR
  } state_t;

  // Byte lanes touched by a write cycle; DATOB picks the lane from address bit 0.
  function automatic logic [1:0] byte_en(input logic [1:0] ctl, input logic a0);
    if (ctl == C_DATOB) return a0 ? 2'b10 : 2'b01;
    return 2'b11;
  endfunction

endpackage

// File: rtl/unibus_memslave_ram.sv
// Single-port word RAM with per-byte write enables and one cycle of read latency.
module unibus_memslave_ram #(
  parameter int ADDRW = 15
) (
  input  logic             clk,
  input  logic             en,
  input  logic [1:0]       we,
  input  logic [ADDRW-1:0] addr,
  input  logic [15:0]      wdata,
  output logic [15:0]      rdata
);

  logic [15:0] mem [0:(1<<ADDRW)-1];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we[0]) mem[addr][7:0]  <= wdata[7:0];
      if (we[1]) mem[addr][15:8] <= wdata[15:8];
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/unibus_memslave.sv
// Unibus slave memory: answers MSYN/SSYN data cycles for an ARM-programmed
// byte window from internal RAM, with an ARM register file and backdoor port.
module unibus_memslave
  import unibus_pkg::*;
#(
  parameter int ADDRW   = 15,
  parameter int QUALCYC = 3
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        armwrite,
  input  logic [2:0]  armraddr,
  input  logic [2:0]  armwaddr,
  input  logic [31:0] armwdata,
  output logic [31:0] armrdata,
  input  logic [17:0] a_in_h,
  input  logic [1:0]  c_in_h,
  input  logic [15:0] d_in_h,
  input  logic        msyn_in_h,
  input  logic        init_in_h,
  output logic [15:0] d_out_h,
  output logic        ssyn_out_h
);

  localparam logic [7:0] QLAST = 8'(QUALCYC - 1);

  state_t           state, state_nxt;
  logic [7:0]       qcnt, qcnt_nxt;
  logic             ssyn_nxt;
  logic [15:0]      dout_nxt;

  logic             enable;
  logic [17:0]      lo, hi;
  logic [31:0]      count;
  logic             bd_busy, bd_wr;
  logic [15:0]      bd_addr, bd_data;

  logic             ram_en;
  logic [1:0]       ram_we;
  logic [ADDRW-1:0] ram_addr;
  logic [15:0]      ram_wdata, ram_rdata;

  logic             bd_done, ssyn_rise, hit;
  logic [17:0]      offset;
  logic             unused_bits;

  assign unused_bits = ^{armwdata[29:18], offset[0], bd_addr};

  // Window hit: inside [lo, hi), below the I/O page, and the word offset fits the RAM.
  assign offset = a_in_h - lo;
  assign hit = enable && (a_in_h >= lo) && (a_in_h < hi) && (a_in_h < IOPAGE_BASE)
            && ({15'd0, offset[17:1]} < (32'd1 << ADDRW));

  unibus_memslave_ram #(.ADDRW(ADDRW)) u_ram (
    .clk   (CLOCK),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      state      <= ST_IDLE;
      qcnt       <= '0;
      ssyn_out_h <= 1'b0;
      d_out_h    <= '0;
    end else begin
      state      <= state_nxt;
      qcnt       <= qcnt_nxt;
      ssyn_out_h <= ssyn_nxt;
      d_out_h    <= dout_nxt;
    end
  end

  // Handshake: the master raises MSYN with address/control/data stable; we raise
  // SSYN (with read data) once the access is done and hold it until MSYN falls.
  always_comb begin
    state_nxt = state;
    qcnt_nxt  = qcnt;
    ssyn_nxt  = ssyn_out_h;
    dout_nxt  = d_out_h;
    ram_en    = 1'b0;
    ram_we    = 2'b00;
    ram_addr  = offset[ADDRW:1];
    ram_wdata = d_in_h;
    bd_done   = 1'b0;
    ssyn_rise = 1'b0;
    if (init_in_h) begin
      state_nxt = ST_IDLE;
      ssyn_nxt  = 1'b0;
      dout_nxt  = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (msyn_in_h) begin
            state_nxt = ST_QUAL;
            qcnt_nxt  = '0;
          end else if (bd_busy) begin
            state_nxt = ST_BDOOR;
            ram_en    = 1'b1;
            ram_addr  = bd_addr[ADDRW-1:0];
            ram_wdata = bd_data;
            ram_we    = bd_wr ? 2'b11 : 2'b00;
          end
        end
        ST_QUAL: begin
          if (!msyn_in_h) begin
            state_nxt = ST_IDLE;
          end else if (qcnt != QLAST) begin
            qcnt_nxt = qcnt + 8'd1;
          end else if (!hit) begin
            state_nxt = ST_NOHIT;
          end else if (c_in_h == C_DATI || c_in_h == C_DATIP) begin
            ram_en    = 1'b1;
            state_nxt = ST_RDWAIT;
          end else begin
            ram_en    = 1'b1;
            ram_we    = byte_en(c_in_h, a_in_h[0]);
            ssyn_nxt  = 1'b1;
            ssyn_rise = 1'b1;
            state_nxt = ST_SSYN;
          end
        end
        ST_RDWAIT: begin
          if (!msyn_in_h) begin
            state_nxt = ST_IDLE;
          end else begin
            dout_nxt  = ram_rdata;
            ssyn_nxt  = 1'b1;
            ssyn_rise = 1'b1;
            state_nxt = ST_SSYN;
          end
        end
        ST_SSYN: begin
          if (!msyn_in_h) begin
            ssyn_nxt  = 1'b0;
            dout_nxt  = '0;
            state_nxt = ST_IDLE;
          end
        end
        ST_NOHIT: begin
          if (!msyn_in_h) state_nxt = ST_IDLE;
        end
        ST_BDOOR: begin
          bd_done   = 1'b1;
          state_nxt = ST_IDLE;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      enable  <= 1'b0;
      lo      <= '0;
      hi      <= '0;
      bd_busy <= 1'b0;
      bd_wr   <= 1'b0;
      bd_addr <= '0;
      bd_data <= '0;
    end else begin
      if (armwrite && armwaddr == 3'd1) begin
        enable <= armwdata[31];
        lo     <= armwdata[17:0];
      end
      if (armwrite && armwaddr == 3'd2) hi <= armwdata[17:0];
      if (armwrite && armwaddr == 3'd4 && !bd_busy) begin
        bd_wr   <= armwdata[30];
        bd_addr <= armwdata[15:0];
        bd_busy <= armwdata[31];
      end
      if (armwrite && armwaddr == 3'd5) bd_data <= armwdata[15:0];
      // A completing backdoor read owns bd_data over a same-cycle ARM write.
      if (bd_done) begin
        bd_busy <= 1'b0;
        if (!bd_wr) bd_data <= ram_rdata;
      end
    end
  end

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      count <= '0;
    end else if (armwrite && armwaddr == 3'd3) begin
      count <= '0;
    end else if (ssyn_rise) begin
      count <= count + 32'd1;
    end
  end

  always_comb begin
    armrdata = BAD_WORD;
    case (armraddr)
      3'd0: armrdata = ID_WORD;
      3'd1: armrdata = {enable, 13'b0, lo};
      3'd2: armrdata = {14'b0, hi};
      3'd3: armrdata = count;
      3'd4: armrdata = {bd_busy, bd_wr, 14'b0, bd_addr};
      3'd5: armrdata = {16'b0, bd_data};
      default: armrdata = BAD_WORD;
    endcase
  end

endmodule

// File: tb/tb_unibus_memslave.sv
// Directed plus randomized bench for unibus_memslave against a behavioural
// model of the window/RAM/count rules.
module tb_unibus_memslave;
  import unibus_pkg::*;

  localparam int ADDRW   = 15;
  localparam int QUALCYC = 3;

  logic        CLOCK = 1'b0;
  logic        RESET = 1'b0;
  logic        armwrite = 1'b0;
  logic [2:0]  armraddr = '0;
  logic [2:0]  armwaddr = '0;
  logic [31:0] armwdata = '0;
  logic [31:0] armrdata;
  logic [17:0] a_in_h = '0;
  logic [1:0]  c_in_h = '0;
  logic [15:0] d_in_h = '0;
  logic        msyn_in_h = 1'b0;
  logic        init_in_h = 1'b0;
  logic [15:0] d_out_h;
  logic        ssyn_out_h;

  int tests = 0;
  int fails = 0;

  // Reference model state
  bit          m_en;
  logic [17:0] m_lo, m_hi;
  logic [31:0] m_count;
  logic [15:0] m_mem [int];
  logic [17:0] pool [16];

  unibus_memslave #(.ADDRW(ADDRW), .QUALCYC(QUALCYC)) dut (
    .CLOCK      (CLOCK),
    .RESET      (RESET),
    .armwrite   (armwrite),
    .armraddr   (armraddr),
    .armwaddr   (armwaddr),
    .armwdata   (armwdata),
    .armrdata   (armrdata),
    .a_in_h     (a_in_h),
    .c_in_h     (c_in_h),
    .d_in_h     (d_in_h),
    .msyn_in_h  (msyn_in_h),
    .init_in_h  (init_in_h),
    .d_out_h    (d_out_h),
    .ssyn_out_h (ssyn_out_h)
  );

  always #5 CLOCK = ~CLOCK;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic arm_wr(input logic [2:0] r, input logic [31:0] v);
    @(negedge CLOCK);
    armwrite = 1'b1; armwaddr = r; armwdata = v;
    @(negedge CLOCK);
    armwrite = 1'b0;
  endtask

  task automatic arm_rd(input logic [2:0] r, output logic [31:0] v);
    armraddr = r;
    #1 v = armrdata;
  endtask

  function automatic bit m_hit(input logic [17:0] a);
    int off;
    off = int'(a) - int'(m_lo);
    return m_en && (a >= m_lo) && (a < m_hi) && (a < 18'o760000) && ((off / 2) < (1 << ADDRW));
  endfunction

  function automatic int m_idx(input logic [17:0] a);
    return (int'(a) - int'(m_lo)) / 2;
  endfunction

  task automatic cfg(input bit en, input logic [17:0] lo, input logic [17:0] hi);
    arm_wr(3'd1, {en, 13'b0, lo});
    arm_wr(3'd2, {14'b0, hi});
    m_en = en; m_lo = lo; m_hi = hi;
  endtask

  task automatic check_count(input string tag);
    logic [31:0] v;
    arm_rd(3'd3, v);
    check(tag, v, m_count);
  endtask

  // One complete master cycle, checked against the model.
  task automatic bus(input string tag, input logic [17:0] a, input logic [1:0] c, input logic [15:0] d);
    bit exp_hit, seen, quiet;
    int lat, idx, budget;
    logic [15:0] got, word;
    exp_hit = m_hit(a);
    idx = m_idx(a);
    seen = 0; quiet = 1; lat = 0; got = '0;
    budget = exp_hit ? 20 : 100;
    @(negedge CLOCK);
    a_in_h = a; c_in_h = c; d_in_h = d; msyn_in_h = 1'b1;
    for (int i = 1; i <= budget && !seen; i++) begin
      @(posedge CLOCK); #1;
      if (ssyn_out_h) begin
        seen = 1; lat = i; got = d_out_h;
      end else if (d_out_h !== 16'h0) begin
        quiet = 0;
      end
    end
    check({tag, " ssyn"}, 32'(seen), 32'(exp_hit));
    if (exp_hit) begin
      check({tag, " latency"}, 32'(lat <= QUALCYC + 2), 32'd1);
      if (c == C_DATI || c == C_DATIP) begin
        if (m_mem.exists(idx)) check({tag, " data"}, 32'(got), 32'(m_mem[idx]));
      end else begin
        word = m_mem.exists(idx) ? m_mem[idx] : 16'h0;
        if (c == C_DATO) word = d;
        else if (a[0]) word[15:8] = d[15:8];
        else word[7:0] = d[7:0];
        m_mem[idx] = word;
      end
      m_count++;
    end else begin
      check({tag, " quiet"}, 32'(quiet), 32'd1);
    end
    @(negedge CLOCK);
    msyn_in_h = 1'b0;
    @(posedge CLOCK); #1;
    check({tag, " release"}, {15'b0, ssyn_out_h, d_out_h}, 32'd0);
  endtask

  task automatic watch_quiet(input string tag, input int n);
    bit quiet;
    quiet = 1;
    for (int i = 0; i < n; i++) begin
      @(posedge CLOCK); #1;
      if (ssyn_out_h !== 1'b0 || d_out_h !== 16'h0) quiet = 0;
    end
    check(tag, 32'(quiet), 32'd1);
  endtask

  task automatic wait_bd_idle(input string tag);
    logic [31:0] v;
    bit done;
    done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge CLOCK);
      arm_rd(3'd4, v);
      if (!v[31]) done = 1;
    end
    check(tag, 32'(done), 32'd1);
  endtask

  task automatic bd_op(input string tag, input bit wr, input logic [15:0] idx,
                       input logic [15:0] wd, output logic [15:0] rd);
    logic [31:0] v;
    if (wr) arm_wr(3'd5, {16'b0, wd});
    arm_wr(3'd4, {1'b1, wr, 14'b0, idx});
    wait_bd_idle({tag, " busy clear"});
    arm_rd(3'd5, v);
    rd = v[15:0];
    if (wr) m_mem[int'(idx)] = wd;
  endtask

  initial begin
    logic [31:0] v;
    logic [15:0] rd;
    bit seen;

    m_en = 0; m_lo = '0; m_hi = '0; m_count = '0;

    // Reset values
    repeat (3) @(negedge CLOCK);
    check("reset ssyn/dout", {15'b0, ssyn_out_h, d_out_h}, 32'd0);
    arm_rd(3'd0, v); check("reg0 id", v, 32'h554D2001);
    arm_rd(3'd1, v); check("reg1 reset", v, 32'd0);
    arm_rd(3'd2, v); check("reg2 reset", v, 32'd0);
    arm_rd(3'd3, v); check("reg3 reset", v, 32'd0);
    arm_rd(3'd4, v); check("reg4 reset", v, 32'd0);
    arm_rd(3'd6, v); check("reg6", v, 32'hDEADBEEF);
    arm_rd(3'd7, v); check("reg7", v, 32'hDEADBEEF);
    @(negedge CLOCK);
    RESET = 1'b1;

    // Basic word write/read
    cfg(1, 18'o000000, 18'o200000);
    arm_rd(3'd1, v); check("reg1 cfg", v, {1'b1, 31'o0});
    arm_rd(3'd2, v); check("reg2 cfg", v, 32'o200000);
    bus("dato 1000", 18'o001000, C_DATO, 16'o123456);
    bus("dati 1000", 18'o001000, C_DATI, 16'h0);
    check("word model", 32'(m_mem[256]), 32'o123456);
    check_count("count after 2");
    check("count is 2", m_count, 32'd2);

    // Byte writes
    bus("datob hi", 18'o001001, C_DATOB, 16'o177777);
    bus("dati hi", 18'o001000, C_DATI, 16'h0);
    check("hi byte model", 32'(m_mem[256]), 32'o177456);
    bus("datob lo", 18'o001000, C_DATOB, 16'o000001);
    bus("datip lo", 18'o001000, C_DATIP, 16'h0);
    check("lo byte model", 32'(m_mem[256]), 32'o177401);

    // Misses and window boundaries
    cfg(1, 18'o740000, 18'o777777);
    bus("below iopage", 18'o757776, C_DATO, 16'h1357);
    bus("below iopage rd", 18'o757776, C_DATI, 16'h0);
    bus("iopage 760000", 18'o760000, C_DATI, 16'h0);
    cfg(1, 18'o000000, 18'o200000);
    bus("addr == hi", 18'o200000, C_DATI, 16'h0);
    bus("hi-1 odd", 18'o177777, C_DATO, 16'h2468);
    cfg(0, 18'o000000, 18'o200000);
    bus("disabled", 18'o001000, C_DATI, 16'h0);
    cfg(1, 18'o000000, 18'o400000);
    bus("beyond ram", 18'o200000, C_DATI, 16'h0);
    bus("last word rd", 18'o177776, C_DATI, 16'h0);
    cfg(1, 18'o000100, 18'o200000);
    bus("below lo", 18'o000076, C_DATI, 16'h0);
    check_count("count after misses");

    // MSYN glitch, then MSYN dropped while the read is in flight
    cfg(1, 18'o000000, 18'o200000);
    @(negedge CLOCK);
    a_in_h = 18'o001000; c_in_h = C_DATO; d_in_h = 16'h0BAD; msyn_in_h = 1'b1;
    @(negedge CLOCK);
    msyn_in_h = 1'b0;
    watch_quiet("glitch no ssyn", 10);
    @(negedge CLOCK);
    c_in_h = C_DATI; msyn_in_h = 1'b1;
    repeat (4) @(negedge CLOCK);
    msyn_in_h = 1'b0;
    watch_quiet("rdwait abort", 10);
    bus("after abort", 18'o001000, C_DATI, 16'h0);
    check_count("count after abort");

    // Backdoor port
    bd_op("bd wr 200", 1, 16'h0200, 16'h55AA, rd);
    check("bd wr readback", 32'(rd), 32'h55AA);
    bus("dati 2000", 18'o002000, C_DATI, 16'h0);
    check("bd model", 32'(m_mem[16'h0200]), 32'o052652);
    bus("dato 3000", 18'o003000, C_DATO, 16'hC3E1);
    bd_op("bd rd 300", 0, 16'h0300, 16'h0, rd);
    check("bd rd data", 32'(rd), 32'(m_mem[16'h0300]));

    // Backdoor requested while a Unibus cycle is in progress
    @(negedge CLOCK);
    a_in_h = 18'o002000; c_in_h = C_DATI; msyn_in_h = 1'b1;
    arm_wr(3'd5, 32'h1234);
    arm_wr(3'd4, {1'b1, 1'b1, 14'b0, 16'h0301});
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge CLOCK); #1;
      if (ssyn_out_h) seen = 1;
    end
    check("held msyn ssyn", 32'(seen), 32'd1);
    check("held msyn data", 32'(d_out_h), 32'(m_mem[16'h0200]));
    m_count++;
    @(negedge CLOCK);
    msyn_in_h = 1'b0;
    wait_bd_idle("held bd busy clear");
    m_mem[16'h0301] = 16'h1234;
    bd_op("bd rd 301", 0, 16'h0301, 16'h0, rd);
    check("held bd data", 32'(rd), 32'h1234);
    check_count("count after backdoor");

    // Count clear
    arm_wr(3'd3, 32'hFFFF_FFFF);
    m_count = '0;
    check_count("count cleared");

    // Randomized traffic over a random window
    cfg(1, 18'(2 * $urandom_range(0, 4096)), 18'o0);
    cfg(1, m_lo, m_lo + 18'o10000);
    for (int i = 0; i < 16; i++) begin
      pool[i] = m_lo + 18'(2 * $urandom_range(0, 2047));
      bus("rand init", pool[i], C_DATO, 16'($urandom));
    end
    for (int k = 0; k < 40; k++) begin
      logic [17:0] ra;
      logic [1:0]  rc;
      if ($urandom_range(0, 7) == 0) ra = m_hi + 18'(2 * $urandom_range(0, 100));
      else ra = pool[$urandom_range(0, 15)] + 18'($urandom_range(0, 1));
      rc = 2'($urandom_range(0, 3));
      bus("rand", ra, rc, 16'($urandom));
    end
    check_count("count after random");

    // INIT during SSYN
    @(negedge CLOCK);
    a_in_h = pool[0]; c_in_h = C_DATI; msyn_in_h = 1'b1;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge CLOCK); #1;
      if (ssyn_out_h) seen = 1;
    end
    check("init pre ssyn", 32'(seen), 32'd1);
    m_count++;
    @(negedge CLOCK);
    init_in_h = 1'b1;
    @(posedge CLOCK); #1;
    check("init clears", {15'b0, ssyn_out_h, d_out_h}, 32'd0);
    @(negedge CLOCK);
    init_in_h = 1'b0; msyn_in_h = 1'b0;
    arm_rd(3'd1, v); check("init keeps cfg", v, {m_en, 13'b0, m_lo});
    check_count("init keeps count");

    // Asynchronous reset mid-cycle
    @(negedge CLOCK);
    a_in_h = pool[1]; c_in_h = C_DATI; msyn_in_h = 1'b1;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge CLOCK); #1;
      if (ssyn_out_h) seen = 1;
    end
    check("reset pre ssyn", 32'(seen), 32'd1);
    @(posedge CLOCK); #2;
    RESET = 1'b0;
    #1;
    check("async reset outputs", {15'b0, ssyn_out_h, d_out_h}, 32'd0);
    arm_rd(3'd1, v); check("async reset reg1", v, 32'd0);
    m_en = 0; m_lo = '0; m_hi = '0; m_count = '0;
    check_count("async reset count");
    @(negedge CLOCK);
    msyn_in_h = 1'b0;
    @(negedge CLOCK);
    RESET = 1'b1;
    cfg(1, 18'o000000, 18'o200000);
    bus("post reset wr", 18'o004000, C_DATO, 16'hA5C3);
    bus("post reset rd", 18'o004000, C_DATI, 16'h0);
    check_count("post reset count");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
